// File: rtl/enc_pkg.sv
// Shared constants and types for the 4-to-2 registered priority encoder.
package enc_pkg;

    localparam int unsigned ENC_N_IN  = 4;
    localparam int unsigned ENC_OUT_W = $clog2(ENC_N_IN);

    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    // Registered result as seen by downstream index consumers.
    typedef struct packed {
        enc_idx_t idx;
        logic     valid;
        logic     multi_hot;
    } enc_result_t;

    localparam enc_result_t ENC_RESULT_IDLE = '{idx: '0, valid: 1'b0, multi_hot: 1'b0};

endpackage : enc_pkg

// File: rtl/prio_enc_core.sv
// Combinational priority encoder: index of the highest set request bit,
// plus "any bit set" and "two or more bits set" flags.
module prio_enc_core #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned OUT_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    output logic [OUT_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scan LSB to MSB so the last (highest) hit overwrites the index;
    // a hit seen while one was already recorded marks the vector multi-hot.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (req[k]) begin
                multi = multi | any;
                any   = 1'b1;
                idx   = OUT_W'(k);
            end
        end
    end

endmodule : prio_enc_core

// File: rtl/encoder_4x2.sv
// Registered 4-to-2 priority encoder. One cycle from I to out/valid/multi_hot;
// outputs come straight from flops so there is no combinational path from I.
module encoder_4x2
    import enc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ENC_N_IN-1:0]  I,
    output logic [ENC_OUT_W-1:0] out,
    output logic                 valid,
    output logic                 multi_hot
);

    enc_idx_t    core_idx;
    logic        core_any;
    logic        core_multi;
    enc_result_t result_q;

    prio_enc_core #(
        .N_IN  (ENC_N_IN),
        .OUT_W (ENC_OUT_W)
    ) u_core (
        .req   (I),
        .idx   (core_idx),
        .any   (core_any),
        .multi (core_multi)
    );

    // Output register stage; synchronous reset takes priority over I.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= ENC_RESULT_IDLE;
        end else begin
            result_q.idx       <= core_idx;
            result_q.valid     <= core_any;
            result_q.multi_hot <= core_multi;
        end
    end

    assign out       = result_q.idx;
    assign valid     = result_q.valid;
    assign multi_hot = result_q.multi_hot;

endmodule : encoder_4x2

// File: tb/tb_encoder_4x2.sv
// Self-checking bench for encoder_4x2 against an arithmetic reference model.
module tb_encoder_4x2;

    logic       clk;
    logic       rst;
    logic [3:0] I;
    logic [1:0] out;
    logic       valid;
    logic       multi_hot;

    int errors = 0;
    int checks = 0;

    encoder_4x2 dut (
        .clk       (clk),
        .rst       (rst),
        .I         (I),
        .out       (out),
        .valid     (valid),
        .multi_hot (multi_hot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {index of highest set bit, popcount>=1, popcount>=2}, zero under reset.
    function automatic logic [3:0] model(input int v, input bit r);
        int hi  = 0;
        int cnt = 0;
        int x   = v;
        if (r) return 4'b0000;
        for (int b = 0; x != 0; b++) begin
            if (x % 2 == 1) begin
                cnt = cnt + 1;
                hi  = b;
            end
            x = x / 2;
        end
        return {2'(hi), cnt >= 1, cnt >= 2};
    endfunction

    // Drive inputs on the falling edge, then settle just past the next rising edge.
    task automatic apply(input logic [3:0] v, input logic r);
        @(negedge clk);
        I   = v;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_v;
        for (int c = 0; c < 2; c++) begin
            apply(4'b1111, 1'b1);
            exp_v = model(15, 1'b1);
            checks++;
            if ({out, valid, multi_hot} !== exp_v) begin
                errors++;
                $display("FAIL reset cycle %0d: got out=%0d valid=%b multi=%b, want out=%0d valid=%b multi=%b",
                         c, out, valid, multi_hot, exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [3:0] exp_v;
        for (int v = 0; v < 16; v++) begin
            apply(4'(v), 1'b0);
            exp_v = model(v, 1'b0);
            checks++;
            if ({out, valid, multi_hot} !== exp_v) begin
                errors++;
                $display("FAIL sweep I=%0d: got out=%0d valid=%b multi=%b, want out=%0d valid=%b multi=%b",
                         v, out, valid, multi_hot, exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_one_hot();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) begin
            v = 4'b0001 << k;
            apply(v, 1'b0);
            checks++;
            if ({out, valid, multi_hot} !== {2'(k), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL one_hot I=%b: got out=%0d valid=%b multi=%b, want out=%0d valid=1 multi=0",
                         v, out, valid, multi_hot, k);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply(4'b1000, 1'b0);
        checks++;
        if ({out, valid, multi_hot} !== 4'b1110) begin
            errors++;
            $display("FAIL mid_reset pre: got out=%0d valid=%b multi=%b, want out=3 valid=1 multi=0",
                     out, valid, multi_hot);
        end
        apply(4'b1000, 1'b1);
        checks++;
        if ({out, valid, multi_hot} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset during: got out=%0d valid=%b multi=%b, want all zero",
                     out, valid, multi_hot);
        end
        apply(4'b1000, 1'b0);
        checks++;
        if ({out, valid, multi_hot} !== 4'b1110) begin
            errors++;
            $display("FAIL mid_reset after: got out=%0d valid=%b multi=%b, want out=3 valid=1 multi=0",
                     out, valid, multi_hot);
        end
    endtask

    task automatic test_back_to_back();
        apply(4'b0110, 1'b0);
        checks++;
        if ({out, valid, multi_hot} !== 4'b1011) begin
            errors++;
            $display("FAIL b2b 0110: got out=%0d valid=%b multi=%b, want out=2 valid=1 multi=1",
                     out, valid, multi_hot);
        end
        apply(4'b0000, 1'b0);
        checks++;
        if ({out, valid, multi_hot} !== 4'b0000) begin
            errors++;
            $display("FAIL b2b 0000: got out=%0d valid=%b multi=%b, want all zero",
                     out, valid, multi_hot);
        end
    endtask

    task automatic test_latency();
        apply(4'b0001, 1'b0);
        // New input applied mid-cycle must not reach the outputs before the edge.
        @(negedge clk);
        I = 4'b1010;
        #2;
        checks++;
        if ({out, valid, multi_hot} !== model(1, 1'b0)) begin
            errors++;
            $display("FAIL latency before edge: got out=%0d valid=%b multi=%b, want out=0 valid=1 multi=0",
                     out, valid, multi_hot);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out, valid, multi_hot} !== model(10, 1'b0)) begin
            errors++;
            $display("FAIL latency after edge: got out=%0d valid=%b multi=%b, want out=3 valid=1 multi=1",
                     out, valid, multi_hot);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic       r;
        logic [3:0] exp_v;
        for (int n = 0; n < 200; n++) begin
            v = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 7) == 0);
            apply(v, r);
            exp_v = model(int'(v), r);
            checks++;
            if ({out, valid, multi_hot} !== exp_v) begin
                errors++;
                $display("FAIL random #%0d I=%b rst=%b: got out=%0d valid=%b multi=%b, want out=%0d valid=%b multi=%b",
                         n, v, r, out, valid, multi_hot, exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        I   = 4'b1111;
        test_reset();
        test_sweep();
        test_one_hot();
        test_mid_reset();
        test_back_to_back();
        test_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_encoder_4x2
